multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Explicit-state control unit for the 32-bit multicycle MIPS datapath. It replaces the opcode-only decoder with a registered FSM.
- Adds a memory wait-state handshake, bne/addi support, illegal-opcode halt and a retired-instruction counter.
- Sits beside the datapath: opcode comes from IR[31:26], zero from the ALU, mem_ready from the memory. It drives every datapath strobe and mux select.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- ENABLE_BNE, 1: 1 = decode bne (000101); 0 = bne is illegal.
- ENABLE_ADDI, 1: 1 = decode addi (001000); 0 = addi is illegal.
- CNT_W, 32: width of retired_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load enable; branch condition already resolved
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- reg_write  out  1  register-file write
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A select: 0 = register A, 1 = PC
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = shifted imm
- alu_op  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct
- pc_source  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug
- illegal_op  out  1  sticky illegal-opcode flag
- retired_count  out  CNT_W  count of completed instructions

Behaviour:
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, addi = 001000.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, HALT 12. Codes 13-15 are unreachable; if entered, go to FETCH.
- Only state, illegal_op, retired_count and a branch-type bit are registered. All other outputs decode combinationally from state, registered branch type, zero and mem_ready.
- Any output not listed for a state is 0.
- Reset (asynchronous): state = FETCH, illegal_op = 0, retired_count = 0. While rst = 1, pc_en, ir_write, reg_write, mem_read and mem_write are forced to 0.
- FETCH:
  - outputs: mem_read = 1, iord = 0, alu_src_a = 1, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_en = rdy.
  - rdy = mem_ready when MEM_WAIT_EN = 1, else 1.
  - holds until rdy, then goes to DECODE.
- DECODE:
  - outputs: alu_src_a = 1, alu_src_b = 11, alu_op = 00.
  - next state: lw/sw -> MEM_ADDR; R -> EXEC; beq/bne -> BRANCH (latch branch type: bne = 1); j -> JUMP; addi -> ADDI_EXEC.
  - any other opcode, or a disabled bne/addi -> HALT, and illegal_op is set.
- MEM_ADDR: alu_src_a = 0, alu_src_b = 10, alu_op = 00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read = 1, iord = 1. Holds until rdy, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEM_WR: mem_write = 1, iord = 1, held until rdy. Goes to FETCH when rdy.
- EXEC: alu_src_a = 0, alu_src_b = 00, alu_op = 10. Goes to R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH:
  - outputs: alu_src_a = 0, alu_src_b = 00, alu_op = 01, pc_source = 01.
  - pc_en = zero for beq, ~zero for bne.
  - goes to FETCH.
- JUMP: pc_source = 10, pc_en = 1. Goes to FETCH.
- ADDI_EXEC: alu_src_a = 0, alu_src_b = 10, alu_op = 00. Goes to ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- HALT: all strobes 0. Stays in HALT until reset; illegal_op stays 1.
- Latency with zero wait states: lw 5 cycles; sw, R and addi 4; beq, bne and j 3. Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- retired_count:
  - increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB.
  - wraps modulo 2^CNT_W; HALT does not count.
- Reset mid-instruction: returns to FETCH immediately. A pending memory access is abandoned, with no write strobe after reset asserts.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the opcode constants and state encodings;
  - the alu_src_b, alu_op and pc_source select encodings.
- One sub-module, mc_ctrl_decode: a purely combinational map from state, branch type, zero and rdy to all strobes and selects. The top module holds the registers and the next-state logic.

Test Plan:
- Reset, then lw with mem_ready = 1 -> state sequence 0, 1, 2, 3, 4, 0; reg_write = 1 and mem_to_reg = 1 only in state 4; retired_count = 1.
- sw with mem_ready low for 3 cycles in MEM_WR -> mem_write and iord stay high for 4 cycles; sw completes in 7 cycles; no reg_write.
- beq with zero = 1, then bne with zero = 1 -> pc_en = 1 with pc_source = 01 for beq; pc_en = 0 in BRANCH for bne.
- FETCH with mem_ready low for 2 cycles -> ir_write and pc_en stay 0, then pulse for exactly 1 cycle.
- Opcode 111111 in DECODE -> HALT (12), illegal_op = 1, all strobes 0 for 20 cycles; rst clears illegal_op and returns to FETCH.
- CNT_W = 4, run 17 R-type instructions -> retired_count = 1 (wrap); assert rst mid-EXEC -> state = 0 asynchronously, retired_count = 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, state codes,
// datapath select values and the bundled control-word type.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode: maps the current state (plus branch type,
// ALU zero and memory ready) onto every datapath strobe and select.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t st,
    input  logic   br_bne,
    input  logic   zero,
    input  logic   rdy,
    output ctrl_t  ctl
);

    always_comb begin
        ctl = '0;
        case (st)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = rdy;
                ctl.pc_en     = rdy;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_SHIMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALUOP_SUB;
                ctl.pc_source = PCSRC_ALUOUT;
                ctl.pc_en     = br_bne ? ~zero : zero;
            end
            S_JUMP: begin
                ctl.pc_source = PCSRC_JUMP;
                ctl.pc_en     = 1'b1;
            end
            S_ADDI_WB: ctl.reg_write = 1'b1;
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Registered control FSM for the multicycle MIPS datapath: state register,
// next-state logic, sticky illegal-opcode flag and retired-instruction counter.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit ENABLE_BNE  = 1'b1,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    state_t cur, nxt;
    logic   br_bne, nxt_bne, set_ill, retire, rdy;
    ctrl_t  ctl;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        nxt     = cur;
        nxt_bne = br_bne;
        set_ill = 1'b0;
        retire  = 1'b0;
        case (cur)
            S_FETCH:  if (rdy) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_R:         nxt = S_EXEC;
                    OP_J:         nxt = S_JUMP;
                    OP_BEQ: begin
                        nxt     = S_BRANCH;
                        nxt_bne = 1'b0;
                    end
                    OP_BNE: begin
                        if (ENABLE_BNE) begin
                            nxt     = S_BRANCH;
                            nxt_bne = 1'b1;
                        end else begin
                            nxt     = S_HALT;
                            set_ill = 1'b1;
                        end
                    end
                    OP_ADDI: begin
                        if (ENABLE_ADDI) begin
                            nxt = S_ADDI_EXEC;
                        end else begin
                            nxt     = S_HALT;
                            set_ill = 1'b1;
                        end
                    end
                    default: begin
                        nxt     = S_HALT;
                        set_ill = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (rdy) nxt = S_MEM_WB;
            S_MEM_WR: begin
                if (rdy) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_EXEC:      nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur           <= S_FETCH;
            br_bne        <= 1'b0;
            illegal_op    <= 1'b0;
            retired_count <= '0;
        end else begin
            cur    <= nxt;
            br_bne <= nxt_bne;
            if (set_ill) illegal_op <= 1'b1;
            if (retire) retired_count <= retired_count + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .st     (cur),
        .br_bne (br_bne),
        .zero   (zero),
        .rdy    (rdy),
        .ctl    (ctl)
    );

    // State-changing strobes must be quiet while reset is held
    assign pc_en      = ctl.pc_en     & ~rst;
    assign ir_write   = ctl.ir_write  & ~rst;
    assign reg_write  = ctl.reg_write & ~rst;
    assign mem_read   = ctl.mem_read  & ~rst;
    assign mem_write  = ctl.mem_write & ~rst;
    assign iord       = ctl.iord;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign pc_source  = ctl.pc_source;
    assign state      = cur;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scenario bench for multicycle_ctrl_fsm: per-cycle expected state/control words
// are queued with their stimulus and compared as each cycle is driven.
module tb_multicycle_ctrl_fsm;

    localparam int TB_CNT_W = 4;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, BAD = 6'b111111;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source}
    localparam logic [14:0] V_FETCH   = 15'b1_0_1_0_1_0_0_0_1_01_00_00;
    localparam logic [14:0] V_FWAIT   = 15'b0_0_1_0_0_0_0_0_1_01_00_00;
    localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_1_11_00_00;
    localparam logic [14:0] V_MADDR   = 15'b0_0_0_0_0_0_0_0_0_10_00_00;
    localparam logic [14:0] V_MRD     = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_MWB     = 15'b0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [14:0] V_MWR     = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [14:0] V_EXEC    = 15'b0_0_0_0_0_0_0_0_0_00_10_00;
    localparam logic [14:0] V_RWB     = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
    localparam logic [14:0] V_BR_T    = 15'b1_0_0_0_0_0_0_0_0_00_01_01;
    localparam logic [14:0] V_BR_N    = 15'b0_0_0_0_0_0_0_0_0_00_01_01;
    localparam logic [14:0] V_JUMP    = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [14:0] V_AWB     = 15'b0_0_0_0_0_0_1_0_0_00_00_00;
    localparam logic [14:0] V_ZERO    = 15'b0;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] v;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
    } ent_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic zero = 1'b0, mem_ready = 1'b1;
    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic illegal_op;
    logic [TB_CNT_W-1:0] retired_count;
    logic [14:0] ctl;

    int errors = 0, checks = 0, exp_cnt = 0;
    ent_t q[$];
    ent_t e;

    always #5 clk = ~clk;

    assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

    multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b1), .ENABLE_BNE(1'b1), .ENABLE_ADDI(1'b1), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .illegal_op(illegal_op), .retired_count(retired_count)
    );

    task automatic push(input logic [3:0] st, input logic [14:0] v, input logic [5:0] op,
                        input logic z, input logic rdy);
        ent_t n;
        n.st = st; n.v = v; n.op = op; n.z = z; n.rdy = rdy;
        q.push_back(n);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({state, illegal_op, retired_count} !== {4'd0, 1'b0, TB_CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_regs got st=%0d ill=%b cnt=%0d want 0/0/0", state, illegal_op, retired_count);
        end
        checks++;
        if ({pc_en, ir_write, reg_write, mem_read, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", {pc_en, ir_write, reg_write, mem_read, mem_write});
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_lw();
        push(0, V_FETCH, LW, 0, 1); push(1, V_DECODE, LW, 0, 1); push(2, V_MADDR, LW, 0, 1);
        push(3, V_MRD, LW, 0, 1);   push(4, V_MWB, LW, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL lw_cycle got st=%0d ctl=%b want st=%0d ctl=%b", state, ctl, e.st, e.v);
            end
        end
        @(posedge clk); #1; exp_cnt++;
        checks++;
        if ({state, retired_count} !== {4'd0, TB_CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL lw_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, retired_count, exp_cnt);
        end
    endtask

    task automatic test_sw_wait();
        push(0, V_FETCH, SW, 0, 1); push(1, V_DECODE, SW, 0, 1); push(2, V_MADDR, SW, 0, 1);
        for (int i = 0; i < 3; i++) push(5, V_MWR, SW, 0, 0);
        push(5, V_MWR, SW, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL sw_cycle got st=%0d ctl=%b want st=%0d ctl=%b", state, ctl, e.st, e.v);
            end
        end
        @(posedge clk); #1; exp_cnt++;
        checks++;
        if ({state, retired_count} !== {4'd0, TB_CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL sw_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, retired_count, exp_cnt);
        end
    endtask

    task automatic test_branch();
        push(0, V_FETCH, BEQ, 1, 1); push(1, V_DECODE, BEQ, 1, 1); push(8, V_BR_T, BEQ, 1, 1);
        push(0, V_FETCH, BNE, 1, 1); push(1, V_DECODE, BNE, 1, 1); push(8, V_BR_N, BNE, 1, 1);
        push(0, V_FETCH, BNE, 0, 1); push(1, V_DECODE, BNE, 0, 1); push(8, V_BR_T, BNE, 0, 1);
        push(0, V_FETCH, BEQ, 0, 1); push(1, V_DECODE, BEQ, 0, 1); push(8, V_BR_N, BEQ, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL branch_cycle op=%b z=%b got st=%0d ctl=%b want st=%0d ctl=%b",
                         e.op, e.z, state, ctl, e.st, e.v);
            end
        end
        @(posedge clk); #1; exp_cnt += 4;
        checks++;
        if ({state, retired_count} !== {4'd0, TB_CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL branch_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, retired_count, exp_cnt);
        end
    endtask

    task automatic test_fetch_wait();
        push(0, V_FWAIT, RT, 0, 0); push(0, V_FWAIT, RT, 0, 0); push(0, V_FETCH, RT, 0, 1);
        push(1, V_DECODE, RT, 0, 0); push(6, V_EXEC, RT, 0, 0); push(7, V_RWB, RT, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL fetch_wait_cycle got st=%0d ctl=%b want st=%0d ctl=%b", state, ctl, e.st, e.v);
            end
        end
        @(posedge clk); #1; exp_cnt++;
        checks++;
        if (retired_count !== TB_CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL fetch_wait_retire got cnt=%0d want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        push(0, V_FETCH, ADDI, 0, 1); push(1, V_DECODE, ADDI, 0, 1);
        push(10, V_MADDR, ADDI, 0, 1); push(11, V_AWB, ADDI, 0, 1);
        push(0, V_FETCH, JMP, 0, 1); push(1, V_DECODE, JMP, 0, 1); push(9, V_JUMP, JMP, 0, 1);
        push(0, V_FETCH, LW, 0, 1); push(1, V_DECODE, LW, 0, 1); push(2, V_MADDR, LW, 0, 1);
        push(3, V_MRD, LW, 0, 0); push(3, V_MRD, LW, 0, 1); push(4, V_MWB, LW, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL b2b_cycle op=%b got st=%0d ctl=%b want st=%0d ctl=%b", e.op, state, ctl, e.st, e.v);
            end
        end
        @(posedge clk); #1; exp_cnt += 3;
        checks++;
        if (retired_count !== TB_CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL b2b_retire got cnt=%0d want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        push(0, V_FETCH, BAD, 0, 1); push(1, V_DECODE, BAD, 0, 1);
        for (int i = 0; i < 20; i++)
            push(12, V_ZERO, BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL illegal_cycle got st=%0d ctl=%b want st=%0d ctl=%b", state, ctl, e.st, e.v);
            end
        end
        checks++;
        if ({illegal_op, retired_count} !== {1'b1, TB_CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL illegal_flag got ill=%b cnt=%0d want ill=1 cnt=%0d", illegal_op, retired_count, exp_cnt);
        end
        #1 rst = 1'b1; #1;
        exp_cnt = 0;
        checks++;
        if ({state, illegal_op, retired_count} !== {4'd0, 1'b0, TB_CNT_W'(0)}) begin
            errors++;
            $display("FAIL illegal_clear got st=%0d ill=%b cnt=%0d want 0/0/0", state, illegal_op, retired_count);
        end
        @(posedge clk); #1; rst = 1'b0; opcode = RT;
    endtask

    task automatic test_wrap_reset();
        for (int n = 0; n < 17; n++) begin
            push(0, V_FETCH, RT, 0, 1); push(1, V_DECODE, RT, 0, 1);
            push(6, V_EXEC, RT, 0, 1);  push(7, V_RWB, RT, 0, 1);
        end
        push(0, V_FETCH, RT, 0, 1); push(1, V_DECODE, RT, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk); opcode = e.op; zero = e.z; mem_ready = e.rdy; #1;
            checks++;
            if ({state, ctl} !== {e.st, e.v}) begin
                errors++;
                $display("FAIL wrap_cycle got st=%0d ctl=%b want st=%0d ctl=%b", state, ctl, e.st, e.v);
            end
        end
        exp_cnt = 17 % (1 << TB_CNT_W);
        @(posedge clk); #1;
        checks++;
        if ({state, retired_count} !== {4'd6, TB_CNT_W'(exp_cnt)}) begin
            errors++;
            $display("FAIL wrap_count got st=%0d cnt=%0d want st=6 cnt=%0d", state, retired_count, exp_cnt);
        end
        #1 rst = 1'b1; #1;
        checks++;
        if ({state, retired_count, pc_en, ir_write, reg_write, mem_read, mem_write} !==
            {4'd0, TB_CNT_W'(0), 5'b0}) begin
            errors++;
            $display("FAIL mid_exec_reset got st=%0d cnt=%0d strobes=%b want 0/0/00000",
                     state, retired_count, {pc_en, ir_write, reg_write, mem_read, mem_write});
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_fetch_wait();
        test_back_to_back();
        test_illegal();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
